// File: rtl/ternary_row_mac.sv
// rtl/ternary_row_mac.sv - ternary weight x signed activation row dot-product engine
// Pops one 2-bit weight per cycle, accumulates per row, emits row results over valid/ready.
module ternary_row_mac #(
   parameter int VecLen   = 16,
   parameter int ActWidth = 8,
   parameter int AccWidth = 32
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        start_i,
   input  logic [15:0]                 num_rows_i,
   output logic                        ready_o,
   input  logic                        act_we_i,
   input  logic [$clog2(VecLen)-1:0]   act_addr_i,
   input  logic [ActWidth-1:0]         act_data_i,
   input  logic [1:0]                  weight_i,
   input  logic                        weight_valid_i,
   output logic                        weight_pop_o,
   output logic [AccWidth-1:0]         result_o,
   output logic [15:0]                 result_row_o,
   output logic                        result_valid_o,
   input  logic                        result_ready_i,
   output logic                        done_o,
   output logic                        err_o
);

   localparam int ColW = $clog2(VecLen);
   localparam logic [ColW-1:0] LastCol = ColW'(VecLen - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_EMIT,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [AccWidth-1:0] acc_q, acc_d;
   logic [ColW-1:0]     col_q, col_d;
   logic [15:0]         row_q, row_d;
   logic [15:0]         num_rows_q, num_rows_d;
   logic [AccWidth-1:0] result_q, result_d;
   logic [15:0]         result_row_q, result_row_d;
   logic                err_q, err_d;

   logic [ActWidth-1:0] act_q [VecLen];
   logic                act_we;
   logic                pop;
   logic [ActWidth-1:0] act_sel;
   logic [AccWidth-1:0] act_ext;
   logic [AccWidth-1:0] term;
   logic [AccWidth-1:0] sum;

   assign act_sel = act_q[col_q];
   assign act_ext = {{(AccWidth-ActWidth){act_sel[ActWidth-1]}}, act_sel};

   // 2'b10 is reserved: it adds nothing but is flagged through err
   always_comb begin
      term = '0;
      case (weight_i)
         2'b01:   term = act_ext;
         2'b11:   term = -act_ext;
         default: term = '0;
      endcase
   end

   assign sum = acc_q + term;

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      col_d        = col_q;
      row_d        = row_q;
      num_rows_d   = num_rows_q;
      result_d     = result_q;
      result_row_d = result_row_q;
      err_d        = err_q;
      act_we       = 1'b0;
      pop          = 1'b0;

      case (state_q)
         S_IDLE: begin
            act_we = act_we_i;
            if (start_i) begin
               num_rows_d = num_rows_i;
               acc_d      = '0;
               col_d      = '0;
               row_d      = '0;
               err_d      = 1'b0;
               state_d    = (num_rows_i == 16'd0) ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            pop = weight_valid_i;
            if (pop) begin
               acc_d = sum;
               if (weight_i == 2'b10) begin
                  err_d = 1'b1;
               end
               if (col_q == LastCol) begin
                  result_d     = sum;
                  result_row_d = row_q;
                  col_d        = '0;
                  state_d      = S_EMIT;
               end else begin
                  col_d = col_q + ColW'(1);
               end
            end
         end
         S_EMIT: begin
            if (result_ready_i) begin
               acc_d = '0;
               if (row_q == num_rows_q - 16'd1) begin
                  state_d = S_DONE;
               end else begin
                  row_d   = row_q + 16'd1;
                  state_d = S_ACCUM;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         acc_q        <= '0;
         col_q        <= '0;
         row_q        <= '0;
         num_rows_q   <= '0;
         result_q     <= '0;
         result_row_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         col_q        <= col_d;
         row_q        <= row_d;
         num_rows_q   <= num_rows_d;
         result_q     <= result_d;
         result_row_q <= result_row_d;
         err_q        <= err_d;
      end
   end

   // Activation storage deliberately has no reset
   always_ff @(posedge clk_i) begin
      if (act_we) begin
         act_q[act_addr_i] <= act_data_i;
      end
   end

   assign ready_o        = (state_q == S_IDLE);
   assign weight_pop_o   = pop;
   assign result_o       = result_q;
   assign result_row_o   = result_row_q;
   assign result_valid_o = (state_q == S_EMIT);
   assign done_o         = (state_q == S_DONE);
   assign err_o          = err_q;

endmodule

// File: tb/tb_ternary_row_mac.sv
// tb/tb_ternary_row_mac.sv - directed table-driven bench for ternary_row_mac
module tb_ternary_row_mac;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [15:0] num_rows_i;
   logic        ready_o;
   logic        act_we_i;
   logic [3:0]  act_addr_i;
   logic [7:0]  act_data_i;
   logic [1:0]  weight_i;
   logic        weight_valid_i;
   logic        weight_pop_o;
   logic [31:0] result_o;
   logic [15:0] result_row_o;
   logic        result_valid_o;
   logic        result_ready_i;
   logic        done_o;
   logic        err_o;

   always #5 clk_i = ~clk_i;

   ternary_row_mac #(.VecLen(16), .ActWidth(8), .AccWidth(32)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .num_rows_i     (num_rows_i),
      .ready_o        (ready_o),
      .act_we_i       (act_we_i),
      .act_addr_i     (act_addr_i),
      .act_data_i     (act_data_i),
      .weight_i       (weight_i),
      .weight_valid_i (weight_valid_i),
      .weight_pop_o   (weight_pop_o),
      .result_o       (result_o),
      .result_row_o   (result_row_o),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .done_o         (done_o),
      .err_o          (err_o)
   );

   typedef struct {
      string             name;
      logic [15:0][7:0]  act;
      int                nrows;
      logic [15:0][1:0]  w0;
      logic [15:0][1:0]  w1;
      bit                gap;
      bit                stall;
      longint            exp0;
      longint            exp1;
      bit                exp_err;
      int                exp_acc;
   } vec_t;

   vec_t tv [9];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic logic [15:0][7:0] act_ramp(input int base);
      logic [15:0][7:0] a;
      for (int i = 0; i < 16; i++) a[i] = 8'(i + base);
      return a;
   endfunction

   function automatic logic [15:0][7:0] act_const(input int v);
      logic [15:0][7:0] a;
      for (int i = 0; i < 16; i++) a[i] = 8'(v);
      return a;
   endfunction

   function automatic logic [15:0][1:0] w_const(input logic [1:0] c);
      logic [15:0][1:0] w;
      for (int i = 0; i < 16; i++) w[i] = c;
      return w;
   endfunction

   function automatic logic [15:0][1:0] w_alt(input logic [1:0] even, input logic [1:0] odd);
      logic [15:0][1:0] w;
      for (int i = 0; i < 16; i++) w[i] = (i % 2 == 0) ? even : odd;
      return w;
   endfunction

   task automatic load_acts(input logic [15:0][7:0] a);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_i);
         act_we_i   = 1'b1;
         act_addr_i = 4'(i);
         act_data_i = a[i];
      end
      @(negedge clk_i);
      act_we_i = 1'b0;
   endtask

   task automatic run_job(input int k);
      int     pops = 0, res_n = 0, done_n = 0, acc_cyc = 0, emit_cyc = 0;
      int     bad_pop = 0, pop_in_emit = 0, unstable = 0, end_cyc = -1;
      bit     seen_done = 0, in_accum;
      logic [31:0] held = '0;
      longint exp_r;
      load_acts(tv[k].act);
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk_i);
         in_accum       = !ready_o && !result_valid_o && !done_o;
         if (cyc == 0) check({tv[k].name, "_ready_idle"}, ready_o, 1);
         start_i        = (cyc == 0);
         num_rows_i     = 16'(tv[k].nrows);
         weight_valid_i = tv[k].gap ? (acc_cyc % 2 == 0) : 1'b1;
         weight_i       = (pops < 16) ? tv[k].w0[pops] : (pops < 32) ? tv[k].w1[pops-16] : 2'b00;
         result_ready_i = !tv[k].stall || emit_cyc >= 5;
         act_we_i       = tv[k].stall && !ready_o;
         act_addr_i     = 4'd15;
         act_data_i     = 8'd0;
         #1;
         if (weight_pop_o) begin
            pops++;
            if (!weight_valid_i) bad_pop++;
         end
         if (in_accum) acc_cyc++;
         if (result_valid_o) begin
            if (weight_pop_o) pop_in_emit++;
            if (emit_cyc == 0) held = result_o;
            else if (result_o !== held) unstable++;
            if (result_ready_i) begin
               exp_r = (res_n == 0) ? tv[k].exp0 : tv[k].exp1;
               check({tv[k].name, "_result"}, $signed(result_o), exp_r);
               check({tv[k].name, "_row"}, result_row_o, res_n);
               res_n++;
               emit_cyc = 0;
            end else begin
               emit_cyc++;
            end
         end
         if (done_o) done_n++;
         if (seen_done && ready_o) begin
            end_cyc = cyc;
            break;
         end
         if (done_o) seen_done = 1;
      end
      start_i        = 1'b0;
      act_we_i       = 1'b0;
      weight_valid_i = 1'b0;
      check({tv[k].name, "_finished"}, (end_cyc >= 0), 1);
      check({tv[k].name, "_pops"}, pops, tv[k].nrows * 16);
      check({tv[k].name, "_results"}, res_n, tv[k].nrows);
      check({tv[k].name, "_done_pulses"}, done_n, 1);
      check({tv[k].name, "_pop_without_valid"}, bad_pop, 0);
      check({tv[k].name, "_pop_in_emit"}, pop_in_emit, 0);
      check({tv[k].name, "_result_unstable"}, unstable, 0);
      check({tv[k].name, "_err"}, err_o, tv[k].exp_err);
      check({tv[k].name, "_accum_cycles"}, acc_cyc, tv[k].exp_acc);
      if (tv[k].nrows == 0) check({tv[k].name, "_ready_return"}, end_cyc, 2);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, ready_o, 1);
      check({tag, "_pop"}, weight_pop_o, 0);
      check({tag, "_result_valid"}, result_valid_o, 0);
      check({tag, "_done"}, done_o, 0);
      check({tag, "_err"}, err_o, 0);
      check({tag, "_result"}, result_o, 0);
      check({tag, "_result_row"}, result_row_o, 0);
   endtask

   task automatic reset_mid_job();
      int pops = 0;
      load_acts(act_ramp(1));
      for (int c = 0; c < 60 && pops < 7; c++) begin
         @(negedge clk_i);
         start_i        = (c == 0);
         num_rows_i     = 16'd1;
         weight_valid_i = 1'b1;
         weight_i       = 2'b01;
         #1;
         if (weight_pop_o) pops++;
      end
      start_i = 1'b0;
      check("midrst_pops_before", pops, 7);
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      check_reset_outputs("midrst_async");
      @(negedge clk_i);
      check_reset_outputs("midrst_held");
      rst_i          = 1'b0;
      weight_valid_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      tv[0] = '{"s1_ramp",  act_ramp(1),    1, w_const(2'b01), w_const(2'b00), 0, 0, 136,  0,    0, 16};
      tv[1] = '{"s2_tworow",act_const(-128),2, w_alt(2'b01, 2'b11), w_const(2'b11), 0, 0, 0, 2048, 0, 32};
      tv[2] = '{"s3_gap",   act_ramp(1),    1, w_const(2'b01), w_const(2'b00), 1, 0, 136,  0,    0, 31};
      tv[3] = '{"s4_stall", act_ramp(1),    1, w_const(2'b11), w_const(2'b00), 0, 1, -136, 0,    0, 16};
      tv[4] = '{"s5_zero",  act_ramp(1),    0, w_const(2'b01), w_const(2'b00), 0, 0, 0,    0,    0, 0};
      tv[5] = '{"s6_err",   act_ramp(1),    1, w_const(2'b01), w_const(2'b00), 0, 0, 132,  0,    1, 16};
      tv[6] = '{"mix_even", act_ramp(1),    1, w_alt(2'b01, 2'b00), w_const(2'b00), 0, 0, 64, 0,   0, 16};
      tv[7] = '{"neg_acts", act_ramp(-8),   1, w_const(2'b11), w_const(2'b00), 0, 0, 8,    0,    0, 16};
      tv[8] = '{"alt_five", act_const(5),   1, w_alt(2'b01, 2'b11), w_const(2'b00), 0, 0, 0, 0,    0, 16};
      tv[5].w0[3] = 2'b10;

      rst_i          = 1'b1;
      start_i        = 1'b0;
      num_rows_i     = '0;
      act_we_i       = 1'b0;
      act_addr_i     = '0;
      act_data_i     = '0;
      weight_i       = '0;
      weight_valid_i = 1'b1;
      result_ready_i = 1'b0;
      #2;
      check_reset_outputs("por");
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      weight_valid_i = 1'b0;

      for (int k = 0; k < 9; k++) run_job(k);
      reset_mid_job();
      run_job(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
